prog_instruction_memory: RTL and testbench

//  Loadable successor to the fixed-program instruction ROM of the 16-bit core.

---
 rtl/prog_instruction_memory.sv | 141 ++++++++++++++
 tb/tb_prog_instruction_memory.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : prog_instruction_memory
//  Description : Loadable instruction RAM with 1-cycle fetch, a programming
//                port and a post-reset clear-to-NOP sequencer.
//                Optional running checksum of programmed words: PROG_CHECKSUM_EN
//  Revision    : 1.0  initial release
// ============================================================================
module prog_instruction_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [15:0]       fetch_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_valid,
    output logic              addr_fault,
    output logic              ready,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ack
`ifdef PROG_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] prog_checksum
`endif
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_PROG  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_instruction;
    logic              r_fetch_valid;
    logic              r_addr_fault;
    logic              r_prog_ack;

    logic              w_oob;
    logic              w_fetch;
    logic              w_prog_wr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Upper address bits only feed the range check; a full 16-bit array has no out-of-range.
    generate
        if (ADDR_W < 16) begin : g_range_check
            assign w_oob = |fetch_addr[15:ADDR_W];
        end else begin : g_full_range
            assign w_oob = 1'b0;
        end
    endgenerate

    assign w_fetch   = (r_state == S_RUN) && fetch_req && !prog_en;
    assign w_prog_wr = (r_state == S_PROG) && prog_en && prog_we;

    assign w_mem_we    = (r_state == S_CLEAR) || w_prog_wr;
    assign w_mem_waddr = (r_state == S_CLEAR) ? r_clr_ptr : prog_addr;
    assign w_mem_wdata = (r_state == S_CLEAR) ? '0 : prog_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_ptr == {ADDR_W{1'b1}}) w_state_nxt = S_RUN;
            S_RUN:   if (prog_en)                     w_state_nxt = S_PROG;
            S_PROG:  if (!prog_en)                    w_state_nxt = S_RUN;
            default:                                  w_state_nxt = S_CLEAR;
        endcase
    end

    // The array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instruction <= '0;
            r_fetch_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
            r_prog_ack    <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch;
            r_prog_ack    <= w_prog_wr;
            if (w_fetch) begin
                r_addr_fault  <= w_oob;
                r_instruction <= w_oob ? '0 : r_mem[fetch_addr[ADDR_W-1:0]];
            end
        end
    end

    assign instruction = r_instruction;
    assign fetch_valid = r_fetch_valid;
    assign addr_fault  = r_addr_fault;
    assign prog_ack    = r_prog_ack;
    assign ready       = (r_state == S_RUN);

`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Restarts on every programming session; held while the core runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if ((r_state == S_RUN) && prog_en) begin
            r_checksum <= '0;
        end else if (w_prog_wr) begin
            r_checksum <= r_checksum + prog_data;
        end
    end

    assign prog_checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_instruction_memory
//  Description : Randomized self-checking bench against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_instruction_memory;

    localparam int M_CLEAR = 0;
    localparam int M_RUN   = 1;
    localparam int M_PROG  = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [15:0] instruction;
    logic        fetch_valid;
    logic        addr_fault;
    logic        ready;
    logic        prog_en;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic        prog_ack;
`ifdef PROG_CHECKSUM_EN
    logic [15:0] prog_checksum;
`endif

    prog_instruction_memory #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .fetch_valid (fetch_valid),
        .addr_fault  (addr_fault),
        .ready       (ready),
        .prog_en     (prog_en),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_ack    (prog_ack)
`ifdef PROG_CHECKSUM_EN
        ,
        .prog_checksum (prog_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: abstract mode, memory image and last-fetch result.
    int          m_mode;
    int          m_clear_left;
    logic [15:0] m_mem [256];
    logic [15:0] m_instr;
    logic        m_fault;
    logic [15:0] m_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Predict the effect of the current inputs on the next edge, clock, compare.
    task automatic step();
        logic exp_ack;
        logic exp_valid;
        exp_ack   = 1'b0;
        exp_valid = 1'b0;
        case (m_mode)
            M_CLEAR: begin
                m_clear_left--;
                if (m_clear_left == 0) m_mode = M_RUN;
            end
            M_RUN: begin
                if (prog_en) begin
                    m_mode = M_PROG;
                    m_sum  = '0;
                end else if (fetch_req) begin
                    exp_valid = 1'b1;
                    if (int'(fetch_addr) >= 256) begin
                        m_instr = 16'h0000;
                        m_fault = 1'b1;
                    end else begin
                        m_instr = m_mem[fetch_addr[7:0]];
                        m_fault = 1'b0;
                    end
                end
            end
            default: begin
                if (prog_en && prog_we) begin
                    m_mem[prog_addr] = prog_data;
                    m_sum            = m_sum + prog_data;
                    exp_ack          = 1'b1;
                end
                if (!prog_en) m_mode = M_RUN;
            end
        endcase
        @(posedge clk);
        #1;
        check("ready", ready, m_mode == M_RUN);
        check("fetch_valid", fetch_valid, exp_valid);
        check("instruction", instruction, m_instr);
        if (exp_valid) check("addr_fault", addr_fault, m_fault);
        check("prog_ack", prog_ack, exp_ack);
`ifdef PROG_CHECKSUM_EN
        check("prog_checksum", prog_checksum, m_sum);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_instruction", instruction, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_addr_fault", addr_fault, 0);
        check("rst_prog_ack", prog_ack, 0);
        check("rst_ready", ready, 0);
`ifdef PROG_CHECKSUM_EN
        check("rst_checksum", prog_checksum, 0);
`endif
        m_mode       = M_CLEAR;
        m_clear_left = 256;
        m_instr      = '0;
        m_fault      = 1'b0;
        m_sum        = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Clear must ignore fetch and programming traffic; bounded in case ready never rises.
    task automatic clear_phase(input int max_steps);
        for (int i = 0; i < max_steps && m_mode == M_CLEAR; i++) begin
            fetch_req  = 1'($urandom);
            fetch_addr = 16'($urandom);
            prog_en    = 1'($urandom);
            prog_we    = 1'($urandom);
            prog_addr  = 8'($urandom);
            prog_data  = 16'($urandom);
            step();
        end
        fetch_req = 1'b0;
        prog_en   = 1'b0;
        prog_we   = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] addr);
        prog_en    = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        step();
        fetch_req  = 1'b0;
    endtask

    task automatic sweep();
        for (int a = 0; a < 256; a++) fetch(16'(a));
    endtask

    task automatic write(input logic [7:0] addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic random_run(input int n);
        prog_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            fetch_req  = 1'($urandom);
            fetch_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            step();
        end
        fetch_req = 1'b0;
    endtask

    // Entry collides with a fetch; exit carries a write that must be dropped.
    task automatic prog_session(input int n, input bit t2, input bit t6);
        prog_en    = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 16'($urandom_range(0, 255));
        step();
        if (t2) begin
            write(8'd0, 16'hA005);
            write(8'd1, 16'hA405);
            write(8'd2, 16'h0000);
        end
        if (t6) begin
            write(8'd250, 16'hFFFF);
            write(8'd251, 16'h0002);
`ifdef PROG_CHECKSUM_EN
            check("t6_checksum", prog_checksum, 16'h0001);
`endif
        end
        for (int i = 0; i < n; i++) begin
            fetch_req  = 1'($urandom);
            fetch_addr = 16'($urandom);
            prog_we    = ($urandom_range(0, 3) != 0);
            prog_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            prog_data  = 16'($urandom);
            step();
        end
        prog_en   = 1'b0;
        prog_we   = 1'b1;
        fetch_req = 1'b1;
        prog_addr = 8'($urandom_range(0, 7));
        prog_data = 16'($urandom);
        step();
        prog_we   = 1'b0;
        fetch_req = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        prog_en    = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        clear_phase(300);
        sweep();

        prog_session(0, 1'b1, 1'b0);
        fetch(16'h0000);
        check("t2_word0", instruction, 16'hA005);
        fetch(16'h0001);
        check("t2_word1", instruction, 16'hA405);
        fetch(16'h0002);
        check("t2_word2", instruction, 16'h0000);

        fetch(16'h0100);
        check("t3_fault", addr_fault, 1);
        fetch(16'h0001);
        check("t3_nofault", addr_fault, 0);

        for (int r = 0; r < 4; r++) begin
            prog_session(30, 1'b0, r == 1);
            sweep();
            random_run(100);
        end
        prog_session(5, 1'b0, 1'b1);
        random_run(40);

        prog_en = 1'b1;
        step();
        write(8'd200, 16'h1234);
        prog_en = 1'b0;
        step();
        fetch(16'd200);
        check("t4_pre_reset", instruction, 16'h1234);
        do_reset();
        clear_phase(100);
        do_reset();
        clear_phase(300);
        fetch(16'd200);
        check("t4_word200", instruction, 16'h0000);
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
